// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: program loader, run-budget sequencer and
// data-memory readback port for the pipelined cpu core.
module cpu_run_ctrl #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cmd_load,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic [31:0] run_cycles,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        rd_req,
  input  logic [$clog2(DMEM_WORDS)-1:0] rd_idx,
  output logic        rd_ready,
  output logic        rd_rvalid,
  output logic [63:0] rd_rdata,
  output logic        cpu_rst_n,
  output logic        cpu_enable,
  output logic [63:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_ren,
  input  logic [63:0] dmem_rdata,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        load_ovf,
  output logic [31:0] cycles_run
);

  localparam int PW =
    (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam logic [PW-1:0] PTR_MAX =
    PW'(IMEM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREP,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] ptr;
  logic [31:0]   budget;
  logic          rd_acc;
  logic          cmd_ok;
  logic          go_load;
  logic          go_start;
  logic          beat;
  logic          beat_end;
  logic          expire;

  // ready flags come straight from state registers
  assign ld_ready = (state == S_LOAD);
  assign rd_ready = (state == S_DONE) &&
                    !dmem_ren && !rd_rvalid;

  // state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_n;
  end

  // event decode and next-state selection
  always_comb begin
    rd_acc   = rd_req && rd_ready;
    // a read in flight (or accepted now) holds commands
    cmd_ok   = (state == S_IDLE) ||
               ((state == S_DONE) &&
                !dmem_ren && !rd_acc);
    go_load  = cmd_ok && cmd_load;
    go_start = cmd_ok && cmd_start && !cmd_load;
    beat     = ld_valid && ld_ready;
    beat_end = beat &&
               (ld_last || (ptr == PTR_MAX));
    expire   = (state == S_RUN) &&
               (cycles_run + 32'd1 == budget);
    state_n  = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (go_load)       state_n = S_LOAD;
        else if (go_start) state_n = S_PREP;
      end
      S_LOAD: begin
        if (beat_end) state_n = S_IDLE;
      end
      S_PREP: begin
        if (budget == 32'd0) state_n = S_DONE;
        else                 state_n = S_RUN;
      end
      S_RUN: begin
        if (expire || cmd_abort) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // datapath, flags and registered core controls
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr        <= '0;
      budget     <= '0;
      imem_wen   <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_ren   <= 1'b0;
      dmem_addr  <= '0;
      rd_rvalid  <= 1'b0;
      rd_rdata   <= '0;
      cpu_rst_n  <= 1'b0;
      cpu_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      load_ovf   <= 1'b0;
      cycles_run <= '0;
    end else begin
      imem_wen  <= 1'b0;
      dmem_ren  <= rd_acc;
      rd_rvalid <= dmem_ren;
      if (rd_acc) dmem_addr <= 64'(rd_idx) << 3;
      if (dmem_ren) rd_rdata <= dmem_rdata;
      if (go_load) begin
        ptr        <= '0;
        load_ovf   <= 1'b0;
        aborted    <= 1'b0;
        cycles_run <= '0;
      end
      if (beat) begin
        imem_wen   <= 1'b1;
        imem_addr  <= 64'(ptr) << 2;
        imem_wdata <= ld_data;
        // pointer parks on the final beat, never wraps
        if (!beat_end) ptr <= ptr + PW'(1);
        if (beat_end && !ld_last) load_ovf <= 1'b1;
      end
      if (go_start) begin
        budget     <= run_cycles;
        cycles_run <= '0;
        aborted    <= 1'b0;
      end
      if (state == S_RUN) begin
        cycles_run <= cycles_run + 32'd1;
        // expiry in the same cycle wins over abort
        if (cmd_abort && !expire) aborted <= 1'b1;
      end
      cpu_rst_n  <= (state_n == S_RUN) ||
                    (state_n == S_DONE);
      cpu_enable <= (state_n == S_RUN);
      busy       <= (state_n == S_LOAD) ||
                    (state_n == S_PREP) ||
                    (state_n == S_RUN);
      done       <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench with a cycle-window
// model of load, run and readback behaviour.
module tb_cpu_run_ctrl;

  localparam int IMEM = 512;
  localparam int BIG  = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cmd_load = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_abort = 1'b0;
  logic [31:0] run_cycles = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        rd_req = 1'b0;
  logic [9:0]  rd_idx = '0;
  logic        rd_ready;
  logic        rd_rvalid;
  logic [63:0] rd_rdata;
  logic        cpu_rst_n;
  logic        cpu_enable;
  logic [63:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_addr;
  logic        dmem_ren;
  logic [63:0] dmem_rdata;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        load_ovf;
  logic [31:0] cycles_run;

  cpu_run_ctrl dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .cmd_load   (cmd_load),
    .cmd_start  (cmd_start),
    .cmd_abort  (cmd_abort),
    .run_cycles (run_cycles),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .rd_req     (rd_req),
    .rd_idx     (rd_idx),
    .rd_ready   (rd_ready),
    .rd_rvalid  (rd_rvalid),
    .rd_rdata   (rd_rdata),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_enable (cpu_enable),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_wdata (imem_wdata),
    .dmem_addr  (dmem_addr),
    .dmem_ren   (dmem_ren),
    .dmem_rdata (dmem_rdata),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .load_ovf   (load_ovf),
    .cycles_run (cycles_run)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in for the core's data memory
  logic [63:0] dmem [16];
  assign dmem_rdata = dmem_ren ?
                      dmem[dmem_addr[6:3]] : 64'd0;

  int checks = 0;
  int failures = 0;
  int en_seen = 0;

  // model: 0 idle after reset, 1 load, 2 run episode
  int mode = 0;
  int ep_p = 0;
  int run_s = 0;
  int run_e = 0;
  int neff = 0;
  int ld_e = BIG;
  int ld_cnt = 0;
  bit exp_abort = 1'b0;
  bit ovf_now = 1'b0;
  bit ld_ovf_new = 1'b0;
  logic [63:0] wr_a [int];
  logic [31:0] wr_d [int];
  logic [63:0] ren_a [int];
  logic [63:0] rv_d [int];
  logic [31:0] prog_w [3];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int tg);
    for (int g = 0; g < 20000 && cyc < tg; g++)
      tick();
  endtask

  task automatic do_load(input int n,
                         input bit with_last,
                         input bit prog);
    logic [31:0] w;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    mode = 1;
    ep_p = cyc;
    ld_e = BIG;
    ld_cnt = 0;
    ld_ovf_new = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = prog ? prog_w[i] :
                 32'hA500_0000 + 32'(i);
      ld_valid = 1'b1;
      ld_data = w;
      ld_last = with_last && (i == n - 1);
      if (ld_e == BIG) begin
        wr_a[cyc + 1] = 64'(ld_cnt) * 64'd4;
        wr_d[cyc + 1] = w;
        if (ld_last || ld_cnt == IMEM - 1) begin
          ld_e = cyc;
          ld_ovf_new = !ld_last;
        end
        ld_cnt++;
      end
      tick();
      if (!prog && i == IMEM - 1) begin
        chk("ovf_last_addr", imem_addr, 64'h7FC);
        chk("ovf_last_wen", imem_wen, 64'd1);
      end
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic start_run(input int n);
    run_cycles = n;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    if (mode == 1) ovf_now = ld_ovf_new;
    mode = 2;
    ep_p = cyc;
    run_s = ep_p + 1;
    neff = n;
    run_e = run_s + n;
    exp_abort = 1'b0;
  endtask

  task automatic abort_at(input int k);
    wait_until(run_s + k);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    if (k + 1 < neff) begin
      neff = k + 1;
      run_e = run_s + neff;
      exp_abort = 1'b1;
    end
  endtask

  task automatic rd(input int idx);
    rd_req = 1'b1;
    rd_idx = 10'(idx);
    ren_a[cyc + 1] = 64'(idx) * 64'd8;
    rv_d[cyc + 2] = dmem[idx];
    tick();
    rd_req = 1'b0;
  endtask

  // per-cycle comparison against the window model
  always @(negedge clk) begin : cmp
    int t;
    logic x_rst, x_en, x_busy, x_done;
    logic x_ab, x_ovf, x_ldr, x_rdr;
    logic [31:0] x_cr;
    t = cyc;
    x_rst = 1'b0;
    x_en = 1'b0;
    x_busy = 1'b0;
    x_done = 1'b0;
    x_ab = 1'b0;
    x_ovf = ovf_now;
    x_ldr = 1'b0;
    x_rdr = 1'b0;
    x_cr = '0;
    if (mode == 1) begin
      x_ldr = (t >= ep_p) && (t <= ld_e);
      x_busy = x_ldr;
      x_ovf = (t > ld_e) ? ld_ovf_new : 1'b0;
    end else if (mode == 2) begin
      x_rst = (t >= run_s);
      x_en = (t >= run_s) && (t < run_e);
      x_busy = (t < run_e);
      x_done = (t >= run_e);
      if (t >= run_s)
        x_cr = 32'((t - run_s < neff) ?
                   t - run_s : neff);
      x_ab = exp_abort && x_done;
      x_rdr = x_done && !ren_a.exists(t) &&
              !rv_d.exists(t);
    end
    chk("cpu_rst_n", cpu_rst_n, x_rst);
    chk("cpu_enable", cpu_enable, x_en);
    chk("busy", busy, x_busy);
    chk("done", done, x_done);
    chk("aborted", aborted, x_ab);
    chk("load_ovf", load_ovf, x_ovf);
    chk("cycles_run", cycles_run, x_cr);
    chk("ld_ready", ld_ready, x_ldr);
    chk("rd_ready", rd_ready, x_rdr);
    if (cpu_enable) en_seen++;
    chk("imem_wen", imem_wen, wr_a.exists(t));
    if (wr_a.exists(t)) begin
      chk("imem_addr", imem_addr, wr_a[t]);
      chk("imem_wdata", imem_wdata, wr_d[t]);
    end
    chk("dmem_ren", dmem_ren, ren_a.exists(t));
    if (ren_a.exists(t))
      chk("dmem_addr", dmem_addr, ren_a[t]);
    chk("rd_rvalid", rd_rvalid, rv_d.exists(t));
    if (rv_d.exists(t))
      chk("rd_rdata", rd_rdata, rv_d[t]);
  end

  initial begin
    prog_w[0] = 32'h0000_0013;
    prog_w[1] = 32'h0010_0093;
    prog_w[2] = 32'h0020_8113;
    for (int i = 0; i < 16; i++)
      dmem[i] = 64'h1111_0000_0000_0000 + 64'(i);
    dmem[3] = 64'hDEAD_BEEF_0000_0001;

    tick();
    tick();
    chk("rst_cpu_rst_n", cpu_rst_n, 64'd0);
    chk("rst_busy", busy, 64'd0);
    arst_n = 1'b1;
    tick();
    tick();

    do_load(3, 1'b1, 1'b1);
    chk("prog_w2_addr", imem_addr, 64'd8);
    chk("prog_w2_data", imem_wdata, 64'h0020_8113);
    chk("prog_ld_ready", ld_ready, 64'd0);
    tick();
    tick();
    chk("prog_ovf", load_ovf, 64'd0);

    do_load(513, 1'b0, 1'b0);
    chk("beat513_nowr", imem_wen, 64'd0);
    chk("stream_ovf", load_ovf, 64'd1);
    tick();

    en_seen = 0;
    start_run(10);
    wait_until(run_e + 2);
    chk("run10_en", 64'(en_seen), 64'd10);
    chk("run10_cnt", cycles_run, 64'd10);
    chk("run10_done", done, 64'd1);
    chk("run10_ab", aborted, 64'd0);

    en_seen = 0;
    start_run(0);
    wait_until(run_e + 2);
    chk("run0_en", 64'(en_seen), 64'd0);
    chk("run0_cnt", cycles_run, 64'd0);
    chk("run0_done", done, 64'd1);

    en_seen = 0;
    start_run(100);
    wait_until(run_s + 1);
    rd_req = 1'b1;
    rd_idx = 10'd3;
    ld_valid = 1'b1;
    ld_data = 32'hFFFF_FFFF;
    cmd_load = 1'b1;
    tick();
    rd_req = 1'b0;
    ld_valid = 1'b0;
    cmd_load = 1'b0;
    abort_at(4);
    wait_until(run_e + 2);
    chk("abort_cnt", cycles_run, 64'd5);
    chk("abort_flag", aborted, 64'd1);
    chk("abort_en", 64'(en_seen), 64'd5);

    start_run(3);
    abort_at(2);
    wait_until(run_e + 2);
    chk("tie_cnt", cycles_run, 64'd3);
    chk("tie_ab", aborted, 64'd0);

    rd(3);
    chk("rd_addr_lit", dmem_addr, 64'd24);
    chk("rd_busy1", rd_ready, 64'd0);
    tick();
    chk("rd_rv_lit", rd_rvalid, 64'd1);
    chk("rd_data_lit", rd_rdata,
        64'hDEAD_BEEF_0000_0001);
    chk("rd_busy2", rd_ready, 64'd0);
    tick();
    chk("rd_idle", rd_ready, 64'd1);
    rd(7);
    tick();
    tick();

    start_run(50);
    wait_until(run_s + 10);
    arst_n = 1'b0;
    mode = 0;
    ovf_now = 1'b0;
    #1;
    chk("arst_en", cpu_enable, 64'd0);
    chk("arst_rst", cpu_rst_n, 64'd0);
    tick();
    tick();
    arst_n = 1'b1;
    tick();
    en_seen = 0;
    start_run(7);
    wait_until(run_e + 2);
    chk("rerun_cnt", cycles_run, 64'd7);
    chk("rerun_en", 64'(en_seen), 64'd7);
    chk("rerun_done", done, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Host-side run controller for the 5-stage pipelined RISC-V `cpu` core. It streams a program into instruction memory over the `cpu` external port and pulses the core's reset. It then holds `enable` high for an exact cycle budget and, once the run ends, serves data-memory readback requests through the second external port. It sits between the testbench/host and the `cpu` instance and owns every `cpu` control input except `clk`.

## Interface
Parameters:
- IMEM_WORDS, 512, instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024, data memory depth in 64-bit words.

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous, active-low reset. One clock domain; polarity and asynchronous assertion are fixed.
- cmd_load  in  1  start program load; sampled in IDLE or DONE.
- cmd_start  in  1  start run; sampled in IDLE or DONE. cmd_load has priority.
- cmd_abort  in  1  end the run early; sampled in RUN only.
- run_cycles  in  32  cycle budget, latched on cmd_start.
- ld_valid / ld_ready / ld_data[31:0] / ld_last  in/out/in/in  program stream handshake.
- rd_req  in  1  readback request; accepted when rd_ready=1.
- rd_idx  in  $clog2(DMEM_WORDS)  data word index.
- rd_ready  out  1  readback port idle.
- rd_rvalid  out  1  single-cycle read response strobe.
- rd_rdata  out  64  read data.
- cpu_rst_n  out  1  drives `cpu` arst_n; registered.
- cpu_enable  out  1  drives `cpu` enable; registered.
- imem_addr/imem_wen/imem_wdata  out  64/1/32  drive addr_ext/wen_ext/wdata_ext. ren_ext is tied 0 by this block.
- dmem_addr/dmem_ren  out  64/1  drive addr_ext_2/ren_ext_2. wen_ext_2 is tied 0 and wdata_ext_2 is tied 0.
- dmem_rdata  in  64  from rdata_ext_2.
- busy  out  1  state is not IDLE or DONE.
- done  out  1  state is DONE.
- aborted  out  1  the last run ended by cmd_abort.
- load_ovf  out  1  the last load was truncated at IMEM_WORDS.
- cycles_run  out  32  enable-high cycles in the last run.

## Operation
- Reset value of every output is 0, except `cpu_rst_n`, which is 0 during reset and stays 0 until the first RUN preparation. All flags clear. State resets to IDLE.
- States and transitions:
  - IDLE → LOAD on cmd_load; IDLE → PREP on cmd_start.
  - LOAD → IDLE when the last beat is accepted.
  - PREP → RUN after one cycle, or → DONE directly if run_cycles==0.
  - RUN → DONE when the budget expires or on cmd_abort.
  - DONE → LOAD on cmd_load; DONE → PREP on cmd_start.
- LOAD:
  - `cpu_rst_n`=0 and `cpu_enable`=0 throughout. Write pointer ptr=0 on entry. `ld_ready`=1.
  - Each beat with ld_valid&ld_ready produces, next cycle, imem_wen=1, imem_addr=ptr*4 (byte address) and imem_wdata=ld_data; then ptr increments.
  - A beat with ld_last=1 ends the load.
  - A beat at ptr==IMEM_WORDS-1 also ends the load. In that case, if ld_last=0, `load_ovf` is set. The pointer never wraps.
  - `ld_ready` drops in the cycle after the final beat.
  - On entry to LOAD, `load_ovf`, `aborted` and `cycles_run` clear.
- PREP: `cpu_rst_n`=0 for exactly one cycle. Counter cleared; run_cycles is latched on cmd_start.
- RUN:
  - `cpu_rst_n`=1 and `cpu_enable`=1 for exactly run_cycles consecutive cycles. `cycles_run` increments once per enable-high cycle.
  - cmd_abort seen in RUN cycle k gives `cpu_enable`=0 from the next cycle, `aborted`=1, and `cycles_run`=k+1.
  - cmd_abort and budget expiry in the same cycle: the result counts as normal completion, `aborted`=0.
- DONE:
  - `cpu_rst_n`=1 and `cpu_enable`=0, so the core state is frozen for inspection. `done`=1. `rd_ready`=1 when no read is pending.
  - rd_req&rd_ready produces, next cycle, dmem_ren=1 and dmem_addr=rd_idx*8.
  - The cycle after that, rd_rvalid=1 and rd_rdata=dmem_rdata.
  - `rd_ready` is 0 from acceptance until rd_rvalid. One request is outstanding at most.
- rd_req outside DONE is ignored. ld_valid outside LOAD is ignored. cmd_* in LOAD, PREP or RUN is ignored, except cmd_abort in RUN.
- cmd_load or cmd_start in DONE while a read is pending: the command waits until rd_rvalid has been issued.
- Asynchronous reset mid-operation returns to IDLE immediately, with `cpu_enable`=0 and `cpu_rst_n`=0. Instruction memory contents are not touched.

## Timing
- All outputs are registered. There are no combinational input→output paths except `ld_ready` and `rd_ready`, which are decoded from state registers only.
- Load throughput is 1 word/cycle; write latency is 1 cycle after the handshake.
- cmd_start to the first `cpu_enable` cycle is 2 cycles (PREP, then RUN).
- The cycle after the last enable-high cycle has `done`=1.
- Readback latency is 2 cycles from accept to rd_rvalid; throughput is 1 read per 3 cycles.
- cycles_run is a 32-bit counter. A run_cycles of 2^32-1 is legal and the counter does not wrap.

## Test plan
- Load 3 words 0x00000013, 0x00100093, 0x00208113 with ld_last on the 3rd beat → imem writes at byte addresses 0, 4, 8 on consecutive cycles; state returns to IDLE; load_ovf=0.
- Stream 513 beats with IMEM_WORDS=512 and ld_last never set → last write at address 0x7FC; ld_ready=0 after beat 512; load_ovf=1; beat 513 is not written.
- cmd_start with run_cycles=10 → cpu_rst_n low for 1 cycle, then cpu_enable high for exactly 10 cycles; done=1, cycles_run=10, aborted=0.
- run_cycles=0 → no enable cycle; done=1, cycles_run=0. Separately: cmd_abort in RUN cycle 4 of 100 → enable low next cycle, cycles_run=5, aborted=1.
- In DONE, rd_req with rd_idx=3 and data memory word 3 = 0xDEADBEEF_00000001 → dmem_addr=24 one cycle later; rd_rvalid with that value two cycles after accept; rd_ready=0 in between.
- arst_n pulsed low mid-RUN → outputs reset asynchronously; a new cmd_start reruns the program without reload, with cycles_run correct for the new run.
